// File: rtl/window_dispatcher.sv
// window_dispatcher: gathers single samples into array_size-sample windows and
// hands each finished window to one of four destinations in round-robin order.
// The fill buffer and the output register form a ping-pong pair, so the next
// window fills while the current one waits for its destination.
module window_dispatcher #(
    parameter int array_size = 9,
    parameter int data_size  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic [data_size-1:0]             in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [data_size*array_size-1:0]  win_data,
    output logic [3:0]                       sel,
    output logic                             win_valid,
    input  logic [3:0]                       dest_ready,
    output logic [15:0]                      win_count
);

    localparam int              CW   = $clog2(array_size + 1);
    localparam logic [CW-1:0]   FULL = CW'(array_size);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                            state;
    state_t                            state_next;
    logic [data_size*array_size-1:0]   fill_buf;
    logic [CW-1:0]                     fill_count;
    logic [1:0]                        dest_ptr;
    logic                              take;
    logic                              accept;
    logic                              transfer;

    // Samples are taken only while the fill buffer has room; a clear drops them.
    assign in_ready = !rst && (fill_count < FULL);
    assign take     = in_valid && in_ready && !clear;

    // Only the ready bit of the currently selected destination counts.
    assign accept   = win_valid && dest_ready[dest_ptr];

    // A full buffer moves to the output as soon as the output is free or is
    // being freed this very cycle.
    assign transfer = (fill_count == FULL) && (!win_valid || accept);

    // Fill buffer: sample k lands in slice k.
    // NOTE: pure datapath storage without reset; every slot is written before
    // fill_count can reach FULL, so its power-up contents are never observed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < array_size; k++) begin
            if (take && (fill_count == CW'(k))) begin
                fill_buf[k*data_size +: data_size] <= in_data;
            end
        end
    end

    // Fill counter: advances per accepted sample, empties on transfer or clear.
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_count <= '0;
        end else if (clear) begin
            fill_count <= '0;
        end else if (transfer) begin
            fill_count <= '0;
        end else if (take) begin
            fill_count <= fill_count + CW'(1);
        end
    end

    // Output window register: loaded on transfer, otherwise holds its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_data <= '0;
        end else if (!clear && transfer) begin
            win_data <= fill_buf;
        end
    end

    // Destination pointer and dispatch counter advance once per accepted window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_ptr  <= '0;
            win_count <= '0;
        end else if (clear) begin
            dest_ptr  <= '0;
            win_count <= '0;
        end else if (accept) begin
            dest_ptr  <= dest_ptr + 2'd1;
            win_count <= win_count + 16'd1;
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Output FSM next state: a transfer in the accept cycle keeps us in HOLD.
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (transfer)            state_next = HOLD;
                HOLD:    if (accept && !transfer) state_next = EMPTY;
                default:                          state_next = EMPTY;
            endcase
        end
    end

    // Output FSM outputs: valid flag and one-hot destination select.
    always_comb begin
        win_valid = (state == HOLD);
        sel       = 4'b0000;
        if (win_valid) begin
            sel = 4'b0001 << dest_ptr;
        end
    end

endmodule

// File: tb/tb_window_dispatcher.sv
// tb_window_dispatcher: directed stimulus with a cycle-level behavioural model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_window_dispatcher;

    localparam int N = 9;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N*W-1:0]   win_data;
    logic [3:0]       sel;
    logic             win_valid;
    logic [3:0]       dest_ready = 4'b0000;
    logic [15:0]      win_count;

    int total = 0;
    int bad   = 0;

    window_dispatcher #(.array_size(N), .data_size(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .win_data   (win_data),
        .sel        (sel),
        .win_valid  (win_valid),
        .dest_ready (dest_ready),
        .win_count  (win_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_fill [N];
    logic [W-1:0] m_win  [N];
    int           m_cnt   = 0;
    bit           m_valid = 1'b0;
    int           m_ptr   = 0;
    logic [15:0]  m_count = '0;
    bit           m_acc;
    bit           m_xfer;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_valid = 0; m_ptr = 0; m_count = '0;
            for (int i = 0; i < N; i++) m_win[i] = '0;
        end else if (clear) begin
            m_cnt = 0; m_valid = 0; m_ptr = 0; m_count = '0;
        end else begin
            m_acc  = m_valid && dest_ready[m_ptr];
            m_xfer = (m_cnt == N) && (!m_valid || m_acc);
            if (in_valid && m_cnt < N) begin
                m_fill[m_cnt] = in_data;
                m_cnt++;
            end
            if (m_acc) begin
                m_ptr   = (m_ptr + 1) % 4;
                m_count = m_count + 16'd1;
                m_valid = 0;
            end
            if (m_xfer) begin
                for (int i = 0; i < N; i++) m_win[i] = m_fill[i];
                m_valid = 1;
                m_cnt   = 0;
            end
        end
    end

    function automatic logic [N*W-1:0] exp_data();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = m_win[i];
        return r;
    endfunction

    function automatic logic [N*W-1:0] pack_seq(input int base);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(base + i);
        return r;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("cyc_in_ready",  in_ready,  (!rst && m_cnt < N));
        check("cyc_win_valid", win_valid, m_valid);
        check("cyc_sel",       sel,       m_valid ? (4'b0001 << m_ptr) : 4'b0000);
        check("cyc_win_data",  win_data,  exp_data());
        check("cyc_win_count", win_count, m_count);
    end

    // Round-robin monitor.
    bit         mon_en  = 1'b0;
    logic [3:0] sel_log[$];
    int         low_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (win_valid) sel_log.push_back(sel);
            if (!in_ready) low_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int v);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = W'(v);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout: got no in_ready for sample %0d expected ready within 50 cycles", v);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!win_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 20), 1'b1);
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_sel",       sel,       4'b0000);
        check("rst_win_data",  win_data,  '0);
        check("rst_win_count", win_count, 16'd0);
        rst = 1'b0;
        dest_ready = 4'b1111;

        // Basic fill: samples 1..9
        for (int i = 1; i <= 9; i++) send(i);
        @(negedge clk);
        check("basic_n1_valid", win_valid, 1'b0);
        @(negedge clk);
        check("basic_valid", win_valid, 1'b1);
        check("basic_lo",    win_data[15:0],    16'd1);
        check("basic_hi",    win_data[143:128], 16'd9);
        check("basic_sel",   sel, 4'b0001);
        @(negedge clk);
        check("basic_count", win_count, 16'd1);
        check("basic_done",  win_valid, 1'b0);

        // Round-robin: 45 samples continuous
        pulse_clear();
        mon_en = 1'b1;
        for (int i = 0; i < 45; i++) send(200 + i);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check("rr_nwin", sel_log.size(), 5);
        if (sel_log.size() == 5) begin
            check("rr_sel0", sel_log[0], 4'b0001);
            check("rr_sel1", sel_log[1], 4'b0010);
            check("rr_sel2", sel_log[2], 4'b0100);
            check("rr_sel3", sel_log[3], 4'b1000);
            check("rr_sel4", sel_log[4], 4'b0001);
        end
        check("rr_ready_low", low_cnt, 5);
        check("rr_count", win_count, 16'd5);

        // Backpressure and wrong-destination ready
        dest_ready = 4'b0000;
        pulse_clear();
        fork
            begin
                for (int i = 1; i <= 27; i++) send(100 + i);
            end
            begin
                repeat (25) @(negedge clk);
                check("bp_valid",    win_valid, 1'b1);
                check("bp_sel",      sel,       4'b0001);
                check("bp_in_ready", in_ready,  1'b0);
                check("bp_data",     win_data,  pack_seq(101));
                repeat (5) @(negedge clk);
                check("bp_stable",   win_data,  pack_seq(101));
                dest_ready = 4'b1110;
                @(negedge clk);
                check("wrong_dest_count", win_count, 16'd0);
                check("wrong_dest_valid", win_valid, 1'b1);
                dest_ready = 4'b0001;
                @(negedge clk);
                check("bp_acc_sel",   sel,       4'b0010);
                check("bp_acc_valid", win_valid, 1'b1);
                check("bp_acc_data",  win_data,  pack_seq(110));
                check("bp_acc_count", win_count, 16'd1);
                dest_ready = 4'b1111;
            end
        join
        repeat (30) @(negedge clk);
        check("bp_total", win_count, 16'd3);

        // Clear with a window held and a partial window
        dest_ready = 4'b0000;
        for (int i = 0; i < 9; i++) send(300 + i);
        for (int i = 0; i < 5; i++) send(400 + i);
        repeat (2) @(negedge clk);
        check("clr_pre_valid", win_valid, 1'b1);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'hdead;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        check("clr_valid",    win_valid, 1'b0);
        check("clr_sel",      sel,       4'b0000);
        check("clr_count",    win_count, 16'd0);
        check("clr_in_ready", in_ready,  1'b1);
        dest_ready = 4'b1111;
        for (int i = 0; i < 9; i++) send(501 + i);
        wait_valid("clr_win_timeout");
        check("clr_win_sel",  sel,      4'b0001);
        check("clr_win_data", win_data, pack_seq(501));

        // Asynchronous reset mid-fill with a window held
        repeat (3) @(negedge clk);
        dest_ready = 4'b0000;
        for (int i = 0; i < 9; i++) send(600 + i);
        for (int i = 0; i < 4; i++) send(650 + i);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_valid",    win_valid, 1'b0);
        check("arst_sel",      sel,       4'b0000);
        check("arst_data",     win_data,  '0);
        check("arst_count",    win_count, 16'd0);
        check("arst_in_ready", in_ready,  1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dest_ready = 4'b1111;
        for (int i = 0; i < 9; i++) send(701 + i);
        wait_valid("arst_win_timeout");
        check("arst_win_sel",  sel,      4'b0001);
        check("arst_win_data", win_data, pack_seq(701));
        repeat (3) @(negedge clk);
        check("arst_win_count", win_count, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000 time units");
        $fatal(1);
    end

endmodule
